// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI register-bank slave: frame width,
// command-byte layout and the protocol FSM states.
package spi_slave_pkg;

    localparam int DATA_W = 8;
    localparam int RW_BIT = 7;

    typedef enum logic [1:0] {
        ST_CMD   = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

endpackage

// File: rtl/spi_shift_core.sv
// Mode-0 serial engine: bit counter, MOSI assembly shifter and MISO
// transmit shifter, all clocked on the SPI clock rising edge.
module spi_shift_core
    import spi_slave_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              csN_i,
    input  logic              mosi_i,
    input  logic              txLoad_i,
    input  logic [DATA_W-1:0] txData_i,
    output logic              miso_o,
    output logic              byteDone_o,
    output logic [DATA_W-1:0] rxByte_o
);

    logic [2:0]        bitCnt_q, bitCnt_d;
    logic [DATA_W-2:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;

    // The completed byte includes the bit being sampled on this edge.
    assign rxByte_o   = {rx_q, mosi_i};
    assign byteDone_o = !csN_i && (bitCnt_q == 3'd7);
    assign miso_o     = tx_q[DATA_W-1];

    always_comb begin
        bitCnt_d = bitCnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        if (csN_i) begin
            bitCnt_d = '0;
        end else begin
            bitCnt_d = bitCnt_q + 3'd1;
            rx_d     = rxByte_o[DATA_W-2:0];
            tx_d     = {tx_q[DATA_W-2:0], 1'b0};
        end
        // A load replaces the shift so the new MSB is on MISO before the next edge.
        if (txLoad_i) begin
            tx_d = txData_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bitCnt_q <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
        end else begin
            bitCnt_q <= bitCnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave fronting a small register bank: a command byte picks
// read or write and a start address, then data bytes stream with auto-increment.
module spi_slave #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = spi_slave_pkg::DATA_W
) (
    input  logic SCLK,
    input  logic rst,
    input  logic CS,
    input  logic MOSI,
    output logic MISO
);

    import spi_slave_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pointer_q, pointer_d;
    logic [DATA_W-1:0] lastRx_q;
    logic [DATA_W-1:0] bank_q [DEPTH];

    logic              byteDone;
    logic [DATA_W-1:0] rxByte;
    logic              txLoad;
    logic [DATA_W-1:0] txData;
    logic              bankWe;
    logic [ADDR_W-1:0] cmdAddr;
    logic [ADDR_W-1:0] pointerInc;

    assign cmdAddr    = rxByte[ADDR_W-1:0];
    assign pointerInc = pointer_q + ADDR_W'(1);

    spi_shift_core u_core (
        .clk_i      (SCLK),
        .rst_i      (rst),
        .csN_i      (CS),
        .mosi_i     (MOSI),
        .txLoad_i   (txLoad),
        .txData_i   (txData),
        .miso_o     (MISO),
        .byteDone_o (byteDone),
        .rxByte_o   (rxByte)
    );

    always_comb begin
        state_d   = state_q;
        pointer_d = pointer_q;
        txLoad    = 1'b0;
        txData    = lastRx_q;
        bankWe    = 1'b0;
        if (CS) begin
            // Deselect edge: re-arm for a new command, preload last byte for CMD phase.
            state_d = ST_CMD;
            txLoad  = 1'b1;
        end else if (byteDone) begin
            txLoad = 1'b1;
            case (state_q)
                ST_CMD: begin
                    pointer_d = cmdAddr;
                    if (rxByte[RW_BIT]) begin
                        state_d = ST_READ;
                        txData  = bank_q[cmdAddr];
                    end else begin
                        state_d = ST_WRITE;
                        txData  = rxByte;
                    end
                end
                ST_READ: begin
                    pointer_d = pointerInc;
                    txData    = bank_q[pointerInc];
                end
                ST_WRITE: begin
                    bankWe    = 1'b1;
                    pointer_d = pointerInc;
                    txData    = rxByte;
                end
                default: begin
                    state_d = ST_CMD;
                end
            endcase
        end
    end

    always_ff @(posedge SCLK) begin
        if (rst) begin
            state_q   <= ST_CMD;
            pointer_q <= '0;
            lastRx_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pointer_q <= pointer_d;
            if (byteDone) begin
                lastRx_q <= rxByte;
            end
            if (bankWe) begin
                bank_q[pointer_q] <= rxByte;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives mode-0 frames on the falling edge
// and checks MISO bytes and key internal state against hand-computed values.
module tb_spi_slave;

    import spi_slave_pkg::*;

    logic SCLK;
    logic rst;
    logic CS;
    logic MOSI;
    logic MISO;

    int total = 0;
    int bad   = 0;

    spi_slave #(.ADDR_W(4), .DATA_W(8)) dut (
        .SCLK (SCLK),
        .rst  (rst),
        .CS   (CS),
        .MOSI (MOSI),
        .MISO (MISO)
    );

    initial begin
        SCLK = 1'b0;
        forever #5 SCLK = ~SCLK;
    end

    // Every task is entered and left just after a falling edge.
    task automatic applyStimulus(input logic [7:0] txByte, output logic [7:0] misoByte);
        for (int i = 7; i >= 0; i--) begin
            CS          = 1'b0;
            MOSI        = txByte[i];
            misoByte[i] = MISO;
            @(negedge SCLK);
        end
    endtask

    task automatic csIdle();
        CS   = 1'b1;
        MOSI = 1'b0;
        @(negedge SCLK);
    endtask

    task automatic test_reset();
        logic [7:0] m;
        rst  = 1'b1;
        CS   = 1'b0;
        MOSI = 1'b1;
        @(negedge SCLK);
        @(negedge SCLK);
        total++;
        if (MISO !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_miso got=%b exp=0", MISO);
        end
        rst = 1'b0;
        applyStimulus(8'hFF, m);
        total++;
        if (m !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_first_byte got=%h exp=00", m);
        end
        total++;
        if (dut.lastRx_q !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL reset_last_rx got=%h exp=ff", dut.lastRx_q);
        end
        total++;
        if (dut.state_q !== ST_READ) begin
            bad++;
            $display("[TB] FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_READ);
        end
        total++;
        if (dut.pointer_q !== 4'hF) begin
            bad++;
            $display("[TB] FAIL reset_pointer got=%h exp=f", dut.pointer_q);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] m;
        csIdle();
        applyStimulus(8'h03, m);
        total++;
        if (m !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL wr_cmd_last_rx got=%h exp=ff", m);
        end
        applyStimulus(8'h5A, m);
        applyStimulus(8'hC3, m);
        csIdle();
        applyStimulus(8'h83, m);
        total++;
        if (m !== 8'hC3) begin
            bad++;
            $display("[TB] FAIL rd_cmd_last_rx got=%h exp=c3", m);
        end
        applyStimulus(8'h00, m);
        total++;
        if (m !== 8'h5A) begin
            bad++;
            $display("[TB] FAIL rd_byte0 got=%h exp=5a", m);
        end
        applyStimulus(8'h00, m);
        total++;
        if (m !== 8'hC3) begin
            bad++;
            $display("[TB] FAIL rd_byte1 got=%h exp=c3", m);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] m;
        csIdle();
        applyStimulus(8'h0F, m);
        applyStimulus(8'h11, m);
        applyStimulus(8'h22, m);
        total++;
        if (dut.bank_q[15] !== 8'h11) begin
            bad++;
            $display("[TB] FAIL wrap_bank15 got=%h exp=11", dut.bank_q[15]);
        end
        total++;
        if (dut.bank_q[0] !== 8'h22) begin
            bad++;
            $display("[TB] FAIL wrap_bank0 got=%h exp=22", dut.bank_q[0]);
        end
        total++;
        if (dut.pointer_q !== 4'h1) begin
            bad++;
            $display("[TB] FAIL wrap_pointer got=%h exp=1", dut.pointer_q);
        end
        csIdle();
        applyStimulus(8'h8F, m);
        total++;
        if (m !== 8'h22) begin
            bad++;
            $display("[TB] FAIL wrap_cmd_last_rx got=%h exp=22", m);
        end
        applyStimulus(8'h00, m);
        total++;
        if (m !== 8'h11) begin
            bad++;
            $display("[TB] FAIL wrap_rd15 got=%h exp=11", m);
        end
        applyStimulus(8'h00, m);
        total++;
        if (m !== 8'h22) begin
            bad++;
            $display("[TB] FAIL wrap_rd0 got=%h exp=22", m);
        end
    endtask

    task automatic test_abort();
        logic [7:0] m;
        csIdle();
        applyStimulus(8'h02, m);
        for (int i = 0; i < 4; i++) begin
            CS   = 1'b0;
            MOSI = 1'b1;
            @(negedge SCLK);
        end
        csIdle();
        total++;
        if (dut.bank_q[2] !== 8'h00) begin
            bad++;
            $display("[TB] FAIL abort_bank2 got=%h exp=00", dut.bank_q[2]);
        end
        total++;
        if (dut.state_q !== ST_CMD) begin
            bad++;
            $display("[TB] FAIL abort_state got=%0d exp=%0d", dut.state_q, ST_CMD);
        end
        applyStimulus(8'h82, m);
        total++;
        if (m !== 8'h02) begin
            bad++;
            $display("[TB] FAIL abort_cmd_last_rx got=%h exp=02", m);
        end
        applyStimulus(8'h00, m);
        total++;
        if (m !== 8'h00) begin
            bad++;
            $display("[TB] FAIL abort_rd2 got=%h exp=00", m);
        end
    endtask

    task automatic test_echo();
        logic [7:0] m;
        csIdle();
        applyStimulus(8'h05, m);
        applyStimulus(8'hA7, m);
        applyStimulus(8'h3C, m);
        total++;
        if (m !== 8'hA7) begin
            bad++;
            $display("[TB] FAIL echo_byte1 got=%h exp=a7", m);
        end
        applyStimulus(8'h00, m);
        total++;
        if (m !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL echo_byte2 got=%h exp=3c", m);
        end
        total++;
        if (dut.bank_q[6] !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL echo_bank6 got=%h exp=3c", dut.bank_q[6]);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] m;
        logic [2:0] part;
        csIdle();
        applyStimulus(8'h83, m);
        total++;
        if (m !== 8'h00) begin
            bad++;
            $display("[TB] FAIL mrst_cmd_last_rx got=%h exp=00", m);
        end
        for (int i = 2; i >= 0; i--) begin
            CS      = 1'b0;
            MOSI    = 1'b0;
            part[i] = MISO;
            @(negedge SCLK);
        end
        total++;
        if (part !== 3'b010) begin
            bad++;
            $display("[TB] FAIL mrst_partial got=%b exp=010", part);
        end
        rst  = 1'b1;
        MOSI = 1'b1;
        @(negedge SCLK);
        rst = 1'b0;
        total++;
        if (MISO !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mrst_miso got=%b exp=0", MISO);
        end
        total++;
        if (dut.state_q !== ST_CMD) begin
            bad++;
            $display("[TB] FAIL mrst_state got=%0d exp=%0d", dut.state_q, ST_CMD);
        end
        total++;
        if (dut.bank_q[3] !== 8'h00 || dut.bank_q[6] !== 8'h00) begin
            bad++;
            $display("[TB] FAIL mrst_bank got=%h/%h exp=00/00", dut.bank_q[3], dut.bank_q[6]);
        end
        csIdle();
        applyStimulus(8'h86, m);
        total++;
        if (m !== 8'h00) begin
            bad++;
            $display("[TB] FAIL mrst_cmd2 got=%h exp=00", m);
        end
        applyStimulus(8'h00, m);
        total++;
        if (m !== 8'h00) begin
            bad++;
            $display("[TB] FAIL mrst_rd6 got=%h exp=00", m);
        end
    endtask

    initial begin
        rst  = 1'b0;
        CS   = 1'b1;
        MOSI = 1'b0;
        test_reset();
        test_write_read();
        test_wrap();
        test_abort();
        test_echo();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning register-bank address width (bank depth 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, fixed at 8, meaning SPI frame and register width.
REQ-003 SHALL have port SCLK  input  1  SPI serial clock, the only clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the SCLK rising edge.
REQ-005 SHALL have port CS  input  1  chip select, active-low.
REQ-006 SHALL have port MOSI  input  1  serial data from master, MSB first.
REQ-007 SHALL have port MISO  output  1  serial data to master, MSB first.

Function
REQ-008 SHALL use SPI mode-0 sampling: capture MOSI on each SCLK rising edge while CS=0.
REQ-009 SHALL drive MISO combinationally from bit 7 of a tx shift register; tx shifts left (LSB fill 0) on each rising edge while CS=0, so master samples bit n before the edge that advances it.
REQ-010 SHALL count bits 0..7 with a 3-bit counter; on the 8th edge the assembled byte (rx_byte) is complete and the counter wraps to 0.
REQ-011 SHALL implement FSM states CMD, WRITE, READ.
REQ-012 SHALL, in CMD: treat byte as {rw[7], ignored[6:ADDR_W], addr[ADDR_W-1:0]}; rw=1 -> READ, rw=0 -> WRITE; latch addr into pointer.
REQ-013 SHALL, on completion of a read command, load tx with bank[addr] on that same edge, so the first READ-phase bit is valid before the next edge.
REQ-014 SHALL, in READ: on each completed byte, increment pointer (wrap modulo 2**ADDR_W) and load tx with bank[pointer+1]; MOSI data ignored.
REQ-015 SHALL, in WRITE: on each completed byte, write rx_byte to bank[pointer], increment pointer (wrap), and load tx with the byte just received (echo).
REQ-016 SHALL, during CMD, shift out last_rx (last complete byte received in any state), loaded at frame start.
REQ-017 SHALL update last_rx on every completed byte.
REQ-018 SHALL, on any rising edge with CS=1: return FSM to CMD, clear bit counter, load tx with last_rx; bank, pointer and last_rx unchanged.
REQ-019 SHALL discard partial bytes when CS rises mid-byte (no bank write).
REQ-020 SHALL require at least one SCLK rising edge with CS=1 between frames; frames without one SHALL continue in current state.
REQ-021 SHALL give rst priority over CS and data activity on the same edge.

Reset
REQ-022 SHALL, on rst=1 at a rising edge: FSM=CMD, bit counter=0, tx=0x00 (MISO=0), last_rx=0x00, pointer=0, all bank entries=0x00.
REQ-023 SHALL hold reset state for every edge with rst=1; normal operation resumes on the first edge with rst=0.

Structure
REQ-024 SHALL place FSM state enum, DATA_W and the rw bit index in shared package spi_slave_pkg.
REQ-025 SHALL implement the bit counter/rx/tx shifters in sub-module spi_shift_core; FSM and register bank stay in spi_slave.

Verification
REQ-026 SHALL test reset: rst=1 for 2 edges, CS=0, MOSI=1 for 8 edges -> MISO all 0 (master sees 0x00), last_rx=0xFF, FSM=READ, pointer=0xF.
REQ-027 SHALL test write/read: frame 0x03,0x5A,0xC3, CS high 1 edge, frame 0x83,0x00,0x00 -> MISO bytes 0xC3(last_rx),0x5A,0xC3.
REQ-028 SHALL test wrap: write 0x0F,0x11,0x22 -> bank[15]=0x11, bank[0]=0x22; read 0x8F -> 0x11 then 0x22.
REQ-029 SHALL test abort: write 0x02 then 4 bits of data, CS high -> bank[2] unchanged (0x00); next frame starts in CMD.
REQ-030 SHALL test mid-frame reset: rst=1 during read data byte -> MISO=0 next bit, bank cleared, FSM=CMD.
REQ-031 SHALL test echo: in WRITE, second data byte shifts out the first data byte exactly.
